// File: rtl/buffer_pkg.sv
// Shared defaults and helpers for the buffer scheduler family.
package buffer_pkg;

   localparam int DEFAULT_NUM_REQ      = 4;
   localparam int DEFAULT_BUFFER_WIDTH = 16;
   localparam int DEFAULT_BUFFER_DEPTH = 8;
   localparam int OCC_W                = $clog2(DEFAULT_BUFFER_DEPTH + 1);
   localparam int MAX_REQ              = 8;

   // Callers narrow the result to their own requester count.
   function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
      logic [MAX_REQ-1:0] v;
      v      = 8'b0000_0000;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/buffer_rr_scheduler_arbiter.sv
// Combinational rotating-priority search: first eligible index at or after rr_ptr wins.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     eligible,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_hit
);

   // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
   always_comb begin
      logic [IDX_W-1:0] idx;
      winner  = {IDX_W{1'b0}};
      any_hit = |eligible;
      idx     = {IDX_W{1'b0}};
      for (int k = N - 1; k >= 0; k--) begin
         idx    = IDX_W'((int'(rr_ptr) + k) % N);
         winner = eligible[idx] ? idx : winner;
      end
   end

endmodule

// File: rtl/buffer_rr_scheduler_chk.sv
// Simulation checks on occupancy bookkeeping of the scheduler.
module buffer_rr_scheduler_chk #(
   parameter int BUFFER_DEPTH = 8,
   parameter int CNT_W        = 4
) (
   input logic             clock,
   input logic             reset,
   input logic [CNT_W-1:0] occupancy,
   input logic             accept,
   input logic             buf_pull
);

   a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
      occupancy <= CNT_W'(BUFFER_DEPTH));

   a_no_underflow: assert property (@(posedge clock) disable iff (!reset)
      buf_pull |-> (occupancy != {CNT_W{1'b0}}));

   a_no_push_full: assert property (@(posedge clock) disable iff (!reset)
      accept |-> (occupancy < CNT_W'(BUFFER_DEPTH)));

endmodule

// File: rtl/buffer_rr_scheduler.sv
// Round-robin push arbitration and valid/ready drain for one shared FIFO buffer.
module buffer_rr_scheduler
   import buffer_pkg::*;
#(
   parameter int NUM_REQ      = DEFAULT_NUM_REQ,
   parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
   parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [NUM_REQ-1:0]                   req,
   input  logic [NUM_REQ*BUFFER_WIDTH-1:0]      req_data,
   output logic [NUM_REQ-1:0]                   gnt,
   output logic                                 buf_push,
   output logic [BUFFER_WIDTH-1:0]              buf_tail,
   output logic                                 buf_pull,
   input  logic [BUFFER_WIDTH-1:0]              buf_head,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [BUFFER_WIDTH-1:0]              out_data,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0]    occupancy,
   output logic                                 full,
   output logic                                 empty
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);

   logic [NUM_REQ-1:0] eligible;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   winner;
   logic               any_hit;
   logic               accept;
   logic [CNT_W-1:0]   valid_count;

   // Masking the just-granted requester prevents a held request being taken twice.
   assign eligible = req & ~gnt;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .winner   (winner),
      .any_hit  (any_hit)
   );

   // A same-cycle pull deliberately does not free space for acceptance.
   assign accept      = any_hit & (occupancy < CNT_W'(BUFFER_DEPTH));
   assign valid_count = occupancy - CNT_W'(buf_push);
   assign out_valid   = (valid_count != {CNT_W{1'b0}});
   assign buf_pull    = out_valid & out_ready;
   assign out_data    = buf_head;
   assign full        = (occupancy == CNT_W'(BUFFER_DEPTH));
   assign empty       = (occupancy == {CNT_W{1'b0}});

   // Grant, push strobe, tail word, pointer and occupancy registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         gnt       <= {NUM_REQ{1'b0}};
         buf_push  <= 1'b0;
         buf_tail  <= {BUFFER_WIDTH{1'b0}};
         rr_ptr    <= {IDX_W{1'b0}};
         occupancy <= {CNT_W{1'b0}};
      end else begin
         if (accept) begin
            gnt      <= NUM_REQ'(onehot(3'(winner)));
            buf_push <= 1'b1;
            buf_tail <= req_data[int'(winner)*BUFFER_WIDTH +: BUFFER_WIDTH];
            rr_ptr   <= (winner == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : winner + IDX_W'(1);
         end else begin
            gnt      <= {NUM_REQ{1'b0}};
            buf_push <= 1'b0;
         end
         occupancy <= occupancy + CNT_W'(accept) - CNT_W'(buf_pull);
      end
   end

   buffer_rr_scheduler_chk #(.BUFFER_DEPTH(BUFFER_DEPTH), .CNT_W(CNT_W)) u_chk (
      .clock     (clock),
      .reset     (reset),
      .occupancy (occupancy),
      .accept    (accept),
      .buf_pull  (buf_pull)
   );

endmodule
